// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: control-bit
// indices, per-boundary widths and the ID/EX payload layout.
package pipe_pkg;

    localparam int CTRL_REGWRITE   = 0;
    localparam int CTRL_MEMTOREG   = 1;
    localparam int CTRL_BRANCH     = 2;
    localparam int CTRL_MEMREAD    = 3;
    localparam int CTRL_MEMWRITE   = 4;
    localparam int CTRL_ALUOP_LSB  = 5;
    localparam int CTRL_ALUSRC_LSB = 7;

    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_CTRL_W  = 9;
    localparam int IDEX_DATA_W  = 153;
    localparam int EXMEM_CTRL_W = 5;
    localparam int EXMEM_DATA_W = 102;
    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_DATA_W = 69;

    // ID/EX payload bit offsets (LSB of each field), matching idex_payload_t
    localparam int IDEX_OFF_RS2    = 0;
    localparam int IDEX_OFF_RS1    = 5;
    localparam int IDEX_OFF_WR     = 10;
    localparam int IDEX_OFF_FUNCT3 = 15;
    localparam int IDEX_OFF_FUNCT7 = 18;
    localparam int IDEX_OFF_IMM    = 25;
    localparam int IDEX_OFF_RD2    = 57;
    localparam int IDEX_OFF_RD1    = 89;
    localparam int IDEX_OFF_PC     = 121;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [6:0]  funct7;
        logic [2:0]  funct3;
        logic [4:0]  wr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } idex_payload_t;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } aluop_e;

    // True when a control word would change architectural state downstream.
    function automatic logic ctrl_has_side_effect(input logic [IDEX_CTRL_W-1:0] ctrl);
        return ctrl[CTRL_REGWRITE] | ctrl[CTRL_MEMWRITE] | ctrl[CTRL_BRANCH];
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// One valid/ready channel carrying a control word and a payload.
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 153
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input  ready);
    modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/pipe_entry.sv
// Single valid-gated storage entry; the control word is zeroed whenever the
// entry is cleared so an empty entry can never present live control bits.
module pipe_entry #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 153
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clr,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);
    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Entry state: clear beats load, payload survives a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= {CTRL_W{1'b0}};
            r_data  <= {DATA_W{1'b0}};
        end else if (i_clr) begin
            r_valid <= 1'b0;
            r_ctrl  <= {CTRL_W{1'b0}};
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and an
// optional skid entry that makes the upstream ready purely registered.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W,
    parameter bit SKID   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush_i,
    pipe_stage_reg_if.slave  up,
    pipe_stage_reg_if.master dn
);
    logic              w_ready;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_m_valid;
    logic              w_m_load;
    logic              w_m_clr;
    logic              w_m_from_s;
    logic [CTRL_W-1:0] w_m_ctrl;
    logic [DATA_W-1:0] w_m_data;
    logic [CTRL_W-1:0] w_m_ctrl_d;
    logic [DATA_W-1:0] w_m_data_d;
    logic              w_s_valid;
    logic              w_s_load;
    logic              w_s_clr;
    logic [CTRL_W-1:0] w_s_ctrl;
    logic [DATA_W-1:0] w_s_data;

    assign w_in_xfer  = up.valid & w_ready;
    assign w_out_xfer = w_m_valid & dn.ready;

    // Entry control: flush first, then drain S into M, then accept input
    always_comb begin
        w_m_load   = 1'b0;
        w_m_clr    = 1'b0;
        w_m_from_s = 1'b0;
        w_s_load   = 1'b0;
        w_s_clr    = 1'b0;
        if (flush_i) begin
            w_m_clr = 1'b1;
            w_s_clr = 1'b1;
        end else if (w_s_valid) begin
            if (w_out_xfer) begin
                w_m_load   = 1'b1;
                w_m_from_s = 1'b1;
                w_s_clr    = 1'b1;
            end else begin
                w_m_load = 1'b0;
            end
        end else if (w_in_xfer) begin
            if (!w_m_valid || w_out_xfer) begin
                w_m_load = 1'b1;
            end else begin
                w_s_load = 1'b1;
            end
        end else if (w_out_xfer) begin
            w_m_clr = 1'b1;
        end else begin
            w_m_clr = 1'b0;
        end
    end

    // Main entry source: the older skid content always goes first
    always_comb begin
        w_m_ctrl_d = up.ctrl;
        w_m_data_d = up.data;
        if (w_m_from_s) begin
            w_m_ctrl_d = w_s_ctrl;
            w_m_data_d = w_s_data;
        end else begin
            w_m_ctrl_d = up.ctrl;
            w_m_data_d = up.data;
        end
    end

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_m_load),
        .i_clr   (w_m_clr),
        .i_ctrl  (w_m_ctrl_d),
        .i_data  (w_m_data_d),
        .o_valid (w_m_valid),
        .o_ctrl  (w_m_ctrl),
        .o_data  (w_m_data)
    );

    generate
        if (SKID) begin : g_skid
            pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_s_load),
                .i_clr   (w_s_clr),
                .i_ctrl  (up.ctrl),
                .i_data  (up.data),
                .o_valid (w_s_valid),
                .o_ctrl  (w_s_ctrl),
                .o_data  (w_s_data)
            );
            assign w_ready = ~w_s_valid;
        end else begin : g_single
            logic w_unused_s;
            assign w_s_valid  = 1'b0;
            assign w_s_ctrl   = {CTRL_W{1'b0}};
            assign w_s_data   = {DATA_W{1'b0}};
            assign w_ready    = ~w_m_valid | dn.ready;
            assign w_unused_s = w_s_load | w_s_clr;
        end
    endgenerate

    assign up.ready = w_ready;
    assign dn.valid = w_m_valid;
    assign dn.ctrl  = w_m_ctrl;
    assign dn.data  = w_m_data;
endmodule
